// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule definitions.
//   NUM_ROUNDS, KEY_W, WORD_W : schedule geometry
//   ks_state_e                : key-generator FSM encoding (IDLE/EXPAND/SERVE)
//   aes_sbox()                : AES forward S-box lookup
//   aes_rcon()                : round constant for round index 1..10, 0 otherwise
package aes_key_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SERVE  = 2'd2
  } ks_state_e;

  // Row-major S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return AES_SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] aes_rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_generator_inv_dec_g_function.sv
// AES key-schedule g() transform: RotWord, SubWord, then XOR of the round
// constant into the top byte. Purely combinational.
//   word   in  32  input word
//   rcon   in  8   round constant
//   g_word out 32  transformed word
module g_function
  import aes_key_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [7:0]        rcon,
  output logic [WORD_W-1:0] g_word
);

  logic [WORD_W-1:0] rot;

  assign rot    = {word[23:0], word[31:24]};
  assign g_word = {aes_sbox(rot[31:24]) ^ rcon,
                   aes_sbox(rot[23:16]),
                   aes_sbox(rot[15:8]),
                   aes_sbox(rot[7:0])};

endmodule

// File: rtl/key_generator_inv_dec.sv
// AES-128 decryption key generator. Expands K0 forward to K10 in ten cycles,
// then presents K10..K0 one per accepted valid/ready beat, stepping the single
// 128-bit work register backward with the inverse schedule recurrence.
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   start          in   begin a schedule with key (IDLE only)
//   abort          in   drop the schedule, back to IDLE (no done)
//   key            in   cipher key K0, sampled when start is accepted
//   key_out        out  current round key (the work register)
//   key_round      out  index of key_out, 10 down to 0
//   key_out_valid  out  key_out/key_round valid
//   key_out_ready  in   consumer accepts key_out this cycle
//   busy           out  state != IDLE
//   done           out  one-cycle pulse after K0 is accepted
// Build option: KEY_SCHED_ZEROIZE_EN clears the work register (and so key_out)
// when leaving SERVE or aborting EXPAND; otherwise the last key is retained.
module key_generator_inv_dec
  import aes_key_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int NUM_ROUNDS   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [BLOCK_LENGTH-1:0] key,
  output logic [BLOCK_LENGTH-1:0] key_out,
  output logic [3:0]              key_round,
  output logic                    key_out_valid,
  input  logic                    key_out_ready,
  output logic                    busy,
  output logic                    done
);

`ifdef KEY_SCHED_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  ks_state_e               state, state_nxt;
  logic [BLOCK_LENGTH-1:0] work, work_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [3:0]              round_nxt;
  logic                    valid_nxt, done_nxt;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] f4, f5, f6, f7;
  logic [31:0] i0, i1, i2, i3;
  logic [31:0] g_in, g_out;
  logic [7:0]  g_rc;
  logic        beat;

  assign {w0, w1, w2, w3} = work;

  // One g() serves both directions: forward uses w3, inverse rebuilds w3 as w7^w6.
  assign g_in = (state == SERVE) ? (w3 ^ w2) : w3;
  assign g_rc = (state == SERVE) ? aes_rcon(key_round) : aes_rcon(cnt + 4'd1);

  g_function u_g (
    .word   (g_in),
    .rcon   (g_rc),
    .g_word (g_out)
  );

  // Forward step K(i) -> K(i+1)
  assign f4 = w0 ^ g_out;
  assign f5 = w1 ^ f4;
  assign f6 = w2 ^ f5;
  assign f7 = w3 ^ f6;

  // Inverse step K(i) -> K(i-1); here {w0..w3} holds {w4..w7} of K(i)
  assign i3 = w3 ^ w2;
  assign i2 = w2 ^ w1;
  assign i1 = w1 ^ w0;
  assign i0 = w0 ^ g_out;

  assign beat    = key_out_valid && key_out_ready;
  assign key_out = work;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    round_nxt = key_round;
    valid_nxt = key_out_valid;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = EXPAND;
          work_nxt  = key;
          cnt_nxt   = 4'd0;
        end
      end
      EXPAND: begin
        if (abort) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          if (ZEROIZE) work_nxt = '0;
        end else begin
          work_nxt = {f4, f5, f6, f7};
          cnt_nxt  = cnt + 4'd1;
          if (cnt == 4'(NUM_ROUNDS - 1)) begin
            state_nxt = SERVE;
            round_nxt = 4'(NUM_ROUNDS);
            valid_nxt = 1'b1;
          end
        end
      end
      SERVE: begin
        // abort outranks a handshake in the same cycle
        if (abort) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          if (ZEROIZE) work_nxt = '0;
        end else if (beat) begin
          if (key_round == 4'd0) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
            if (ZEROIZE) work_nxt = '0;
          end else begin
            work_nxt  = {i0, i1, i2, i3};
            round_nxt = key_round - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      work          <= '0;
      cnt           <= 4'd0;
      key_round     <= 4'd0;
      key_out_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      work          <= work_nxt;
      cnt           <= cnt_nxt;
      key_round     <= round_nxt;
      key_out_valid <= valid_nxt;
      done          <= done_nxt;
    end
  end

endmodule

// File: tb/tb_key_generator_inv_dec.sv
module tb_key_generator_inv_dec;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] key_out;
  logic [3:0]   key_round;
  logic         key_out_valid;
  logic         key_out_ready = 1'b0;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] keys [0:1][0:10];

`ifdef KEY_SCHED_ZEROIZE_EN
  localparam bit ZZ = 1'b1;
`else
  localparam bit ZZ = 1'b0;
`endif

  key_generator_inv_dec dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .key           (key),
    .key_out       (key_out),
    .key_round     (key_round),
    .key_out_valid (key_out_valid),
    .key_out_ready (key_out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept start at the next edge, then check K10 appears exactly ten edges later.
  task automatic launch(input int sel);
    key   = keys[sel][0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("launch_busy", busy, 1);
    chk("launch_valid_early", key_out_valid, 0);
    repeat (9) tick();
    chk("expand_valid_t9", key_out_valid, 0);
    tick();
    chk("k10_valid", key_out_valid, 1);
    chk("k10_round", key_round, 10);
    chk("k10_key", key_out, keys[sel][10]);
  endtask

  // Drain with ready high; returns in the cycle where done is high.
  task automatic drain(input int sel);
    key_out_ready = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      chk("drain_valid", key_out_valid, 1);
      chk("drain_round", key_round, 128'(r));
      chk("drain_key", key_out, keys[sel][r]);
      chk("drain_no_done", done, 0);
      tick();
    end
    chk("drain_done", done, 1);
    chk("drain_valid_low", key_out_valid, 0);
    chk("drain_busy_low", busy, 0);
  endtask

  initial begin
    logic [63:0]  pat;
    int           exp_r;
    int           acc;
    bit           got_done;
    bit           prev_hold;
    logic [127:0] prev_key;

    keys[0][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    keys[0][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    keys[0][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    keys[0][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    keys[0][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    keys[0][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    keys[0][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    keys[0][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    keys[0][8]  = 128'head27321b58dbad2312bf5607f8d292f;
    keys[0][9]  = 128'hac7766f319fadc2128d12941575c006e;
    keys[0][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    keys[1][0]  = 128'h00000000000000000000000000000000;
    keys[1][1]  = 128'h62636363626363636263636362636363;
    keys[1][2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    keys[1][3]  = 128'h90973450696ccffaf2f457330b0fac99;
    keys[1][4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    keys[1][5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    keys[1][6]  = 128'hec614b851425758c99ff09376ab49ba7;
    keys[1][7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    keys[1][8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    keys[1][9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    keys[1][10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // Reset state
    #2;
    chk("rst_valid", key_out_valid, 0);
    chk("rst_round", key_round, 0);
    chk("rst_key", key_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", key_out_valid, 0);

    // Full schedule with ready high
    key_out_ready = 1'b1;
    launch(0);
    drain(0);
    tick();
    chk("done_once", done, 0);
    chk("idle_key_after_done", key_out, ZZ ? 128'h0 : keys[0][0]);
    chk("idle_round_after_done", key_round, 0);

    // Irregular ready pattern: stable data while stalled, 11 beats in order
    key_out_ready = 1'b0;
    launch(0);
    pat = 64'hB5C39A6E1F70D24B;
    exp_r = 10; acc = 0; got_done = 1'b0; prev_hold = 1'b0; prev_key = '0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (key_out_valid) begin
        chk("rnd_round", key_round, 128'(exp_r));
        chk("rnd_key", key_out, keys[0][exp_r]);
        if (prev_hold) chk("rnd_hold", key_out, prev_key);
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        key_out_ready = pat[c % 64];
        if (key_out_valid && key_out_ready) begin
          acc++;
          exp_r--;
        end
        prev_hold = key_out_valid && !key_out_ready;
        prev_key  = key_out;
        tick();
      end
    end
    chk("rnd_done_seen", got_done, 1);
    chk("rnd_beats", 128'(acc), 11);
    tick();
    chk("rnd_done_once", done, 0);

    // Abort at round 5 together with ready
    key_out_ready = 1'b1;
    launch(0);
    repeat (5) tick();
    chk("pre_abort_round", key_round, 5);
    chk("pre_abort_key", key_out, keys[0][5]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", key_out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    chk("abort_key", key_out, ZZ ? 128'h0 : keys[0][5]);
    tick();
    chk("abort_no_done_later", done, 0);
    launch(0);
    drain(0);
    tick();

    // start pulses during EXPAND and SERVE are ignored
    key_out_ready = 1'b0;
    key   = keys[0][0];
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    key   = keys[1][0];
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("ign_valid_t9", key_out_valid, 0);
    tick();
    chk("ign_valid_t10", key_out_valid, 1);
    chk("ign_key_k10", key_out, keys[0][10]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_serve_round", key_round, 10);
    chk("ign_serve_key", key_out, keys[0][10]);
    tick();
    chk("stall_key", key_out, keys[0][10]);
    chk("stall_valid", key_out_valid, 1);
    drain(0);
    tick();

    // Asynchronous reset mid-EXPAND
    key   = keys[0][0];
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_key", key_out, 0);
    chk("arst_round", key_round, 0);
    chk("arst_valid", key_out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("arst_idle", busy, 0);

    // Back-to-back: start in the done cycle with a second key
    key_out_ready = 1'b1;
    launch(0);
    drain(0);
    launch(1);
    drain(1);
    tick();
    chk("b2b_done_once", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
